ram_port_arbiter: RTL and testbench

//  Shares the single 8-bit data RAM between the CPU memory stage and a host/DMA port (loader, debugger).

---
 rtl/ram_port_arbiter_if.sv | 20 ++
 rtl/ram_port_arbiter.sv | 93 +++++++++
 tb/tb_ram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: host/DMA access port of the RAM arbiter
interface ram_port_arbiter_if;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdat;
    logic       host_ack;
    logic       host_rvalid;
    logic [7:0] host_rdat;

    modport master (
        output host_req, host_we, host_addr, host_wdat,
        input  host_ack, host_rvalid, host_rdat
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdat,
        output host_ack, host_rvalid, host_rdat
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 8-bit RAM between the CPU memory stage and a host/DMA port
module ram_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int HOST_WAIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [7:0]                cpu_addr,
    input  logic [7:0]                cpu_wdat,
    input  logic                      cpu_rd_,
    input  logic                      cpu_wr_,
    output logic [7:0]                cpu_rdat,
    output logic                      cpu_stall,
    ram_port_arbiter_if.slave         host,
    output logic [7:0]                ram_addr,
    output logic [7:0]                ram_wdat,
    output logic                      ram_rd_,
    output logic                      ram_wr_,
    input  logic [7:0]                ram_rdat
);
    typedef enum logic {OWN_CPU, OWN_HOST} own_t;

    localparam logic [3:0] MB = 4'(MAX_BURST);
    localparam logic [3:0] HW = 4'(HOST_WAIT);

    own_t       own_q, own_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rvalid_q, rvalid_d;
    logic [7:0] rdat_q, rdat_d;
    logic       cpu_acc, host_go, cpu_go;

    assign cpu_acc          = ~cpu_rd_ | ~cpu_wr_;
    assign cpu_rdat         = ram_rdat;
    assign host.host_rvalid = rvalid_q;
    assign host.host_rdat   = rdat_q;

    // RAM pin steering from the registered owner; strobes are forced inactive while in reset
    always_comb begin
        host_go        = rst_ && own_q == OWN_HOST && host.host_req;
        cpu_go         = rst_ && own_q == OWN_CPU;
        host.host_ack  = host_go;
        cpu_stall      = rst_ && own_q == OWN_HOST && cpu_acc;
        ram_addr       = host_go ? host.host_addr : cpu_addr;
        ram_wdat       = host_go ? host.host_wdat : cpu_wdat;
        ram_wr_        = host_go ? ~host.host_we : ~(cpu_go && ~cpu_wr_);
        ram_rd_        = host_go ? host.host_we  : ~(cpu_go && ~cpu_rd_ && cpu_wr_);
    end

    // Ownership decision: host steals idle slots, is forced in after HOST_WAIT busy cycles, yields after MAX_BURST
    always_comb begin
        own_d       = own_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        rvalid_d    = host_go && !host.host_we;
        rdat_d      = rvalid_d ? ram_rdat : rdat_q;
        if (own_q == OWN_CPU) begin
            burst_cnt_d = '0;
            if (!host.host_req) begin
                wait_cnt_d = '0;
            end else if (!cpu_acc || wait_cnt_q == HW - 4'd1) begin
                own_d      = OWN_HOST;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end else begin
            burst_cnt_d = (host_go && burst_cnt_q != MB) ? burst_cnt_q + 4'd1 : burst_cnt_q;
            if (!host.host_req || (cpu_acc && burst_cnt_d == MB)) begin
                own_d       = OWN_CPU;
                burst_cnt_d = '0;
                wait_cnt_d  = '0;
            end
        end
    end

    // State and host read-data registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            own_q       <= OWN_CPU;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            rdat_q      <= '0;
        end else begin
            own_q       <= own_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            rdat_q      <= rdat_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized traffic against a cycle-level ownership model
module tb_ram_port_arbiter;
    localparam int MAX_BURST = 4;
    localparam int HOST_WAIT = 8;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       load = 1'b1;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdat = '0;
    logic       cpu_rd_ = 1'b1;
    logic       cpu_wr_ = 1'b1;
    logic [7:0] cpu_rdat, ram_addr, ram_wdat, ram_rdat;
    logic       cpu_stall, ram_rd_, ram_wr_;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         checks = 0;
    int         failures = 0;

    ram_port_arbiter_if h();

    ram_port_arbiter #(.MAX_BURST(MAX_BURST), .HOST_WAIT(HOST_WAIT)) dut (
        .clk(clk), .rst_(rst_),
        .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat), .cpu_rd_(cpu_rd_), .cpu_wr_(cpu_wr_),
        .cpu_rdat(cpu_rdat), .cpu_stall(cpu_stall),
        .host(h),
        .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_rd_(ram_rd_), .ram_wr_(ram_wr_),
        .ram_rdat(ram_rdat)
    );

    always #5 clk = ~clk;

    // Physical RAM: combinational read, write on rising edge while ram_wr_ low
    assign ram_rdat = mem[ram_addr];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (!ram_wr_) begin
            mem[ram_addr] <= ram_wdat;
        end
    end

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        cpu_rd_ = rd; cpu_wr_ = wr; cpu_addr = a; cpu_wdat = d;
    endtask

    task automatic host_op(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
        h.host_req = req; h.host_we = we; h.host_addr = a; h.host_wdat = d;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (h.host_ack) break;
            n++;
            tick;
        end
    endtask

    task automatic count_acks(input logic [7:0] base, output int k, output int st);
        k = 0; st = 0;
        while (k < 12 && h.host_ack) begin
            if (cpu_stall) st++;
            k++;
            tick;
            h.host_addr = base + 8'(k);
            h.host_wdat = 8'(k);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        cpu_op(1'b1, 1'b0, 8'h10, 8'h5A);
        host_op(1'b1, 1'b1, 8'h11, 8'h77);
        @(negedge clk);
        checks++; if (ram_wr_ !== 1'b1) begin failures++; $display("FAIL reset_ram_wr got=%b exp=1", ram_wr_); end
        checks++; if (ram_rd_ !== 1'b1) begin failures++; $display("FAIL reset_ram_rd got=%b exp=1", ram_rd_); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        checks++; if (h.host_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", h.host_ack); end
        checks++; if (h.host_rvalid !== 1'b0 || h.host_rdat !== 8'h00) begin failures++; $display("FAIL reset_rvalid got=%b/%h exp=0/00", h.host_rvalid, h.host_rdat); end
        tick; tick;
        checks++; if (mem[8'h10] !== init_val(8'h10)) begin failures++; $display("FAIL reset_no_write got=%h exp=%h", mem[8'h10], init_val(8'h10)); end
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        rst_ = 1'b1;
        @(negedge clk);
        checks++; if ({ram_wr_, ram_addr, ram_wdat} !== {1'b0, 8'h10, 8'h5A}) begin failures++; $display("FAIL release_cpu_write got=%b/%h/%h exp=0/10/5a", ram_wr_, ram_addr, ram_wdat); end
        tick;
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        checks++; if (mem[8'h10] !== 8'h5A) begin failures++; $display("FAIL release_mem got=%h exp=5a", mem[8'h10]); end
    endtask

    task automatic test_idle_steal;
        host_op(1'b1, 1'b1, 8'h20, 8'hA5);
        @(negedge clk);
        checks++; if (h.host_ack !== 1'b0) begin failures++; $display("FAIL steal_no_comb_grant got=%b exp=0", h.host_ack); end
        tick;
        @(negedge clk);
        checks++; if ({h.host_ack, ram_wr_, ram_rd_, ram_addr} !== {1'b1, 1'b0, 1'b1, 8'h20}) begin failures++; $display("FAIL steal_ack got=%b%b%b/%h exp=101/20", h.host_ack, ram_wr_, ram_rd_, ram_addr); end
        tick;
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b0, 1'b1, 8'h20, 8'h00);
        @(negedge clk);
        checks++; if ({cpu_stall, h.host_ack} !== 2'b10) begin failures++; $display("FAIL steal_tail_stall got=%b%b exp=10", cpu_stall, h.host_ack); end
        tick;
        @(negedge clk);
        checks++; if ({cpu_stall, ram_rd_, cpu_rdat} !== {2'b00, 8'hA5}) begin failures++; $display("FAIL steal_cpu_ld got=%b%b/%h exp=00/a5", cpu_stall, ram_rd_, cpu_rdat); end
        tick;
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
    endtask

    task automatic test_forced;
        int n, k, st;
        cpu_op(1'b0, 1'b1, 8'h30, 8'h00);
        host_op(1'b1, 1'b1, 8'h40, 8'h00);
        wait_ack(n);
        checks++; if (n !== HOST_WAIT) begin failures++; $display("FAIL forced_wait got=%0d exp=%0d", n, HOST_WAIT); end
        count_acks(8'h40, k, st);
        checks++; if (k !== MAX_BURST || st !== MAX_BURST) begin failures++; $display("FAIL forced_burst acks=%0d stalls=%0d exp=%0d", k, st, MAX_BURST); end
        checks++; if ({cpu_stall, ram_rd_, ram_addr, cpu_rdat} !== {2'b00, 8'h30, init_val(8'h30)}) begin failures++; $display("FAIL forced_cpu_resume got=%b%b/%h/%h exp=00/30/%h", cpu_stall, ram_rd_, ram_addr, cpu_rdat, init_val(8'h30)); end
        tick;
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
        checks++; if (mem[8'h43] !== 8'h03 || mem[8'h44] !== init_val(8'h44)) begin failures++; $display("FAIL forced_mem got=%h/%h exp=03/%h", mem[8'h43], mem[8'h44], init_val(8'h44)); end
    endtask

    task automatic test_burst_hold;
        host_op(1'b1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checks++; if (h.host_ack !== 1'b0) begin failures++; $display("FAIL burst_first got=%b exp=0", h.host_ack); end
        tick;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (h.host_ack !== 1'b1) begin failures++; $display("FAIL burst_ack%0d got=%b exp=1", i, h.host_ack); end
            if (i > 0) begin
                checks++; if ({h.host_rvalid, h.host_rdat} !== {1'b1, init_val(8'(i - 1))}) begin failures++; $display("FAIL burst_rdat%0d got=%b/%h exp=1/%h", i - 1, h.host_rvalid, h.host_rdat, init_val(8'(i - 1))); end
            end
            tick;
            h.host_addr = 8'(i + 1);
            if (i == 9) h.host_req = 1'b0;
        end
        @(negedge clk);
        checks++; if ({h.host_ack, h.host_rvalid, h.host_rdat} !== {2'b01, init_val(8'h09)}) begin failures++; $display("FAIL burst_last got=%b%b/%h exp=01/%h", h.host_ack, h.host_rvalid, h.host_rdat, init_val(8'h09)); end
        tick;
        @(negedge clk);
        checks++; if (h.host_rvalid !== 1'b0) begin failures++; $display("FAIL burst_rvalid_drop got=%b exp=0", h.host_rvalid); end
        tick;
    endtask

    task automatic test_release;
        int n, k, st;
        cpu_op(1'b0, 1'b1, 8'h31, 8'h00);
        host_op(1'b1, 1'b1, 8'h70, 8'h00);
        wait_ack(n);
        checks++; if (n !== HOST_WAIT) begin failures++; $display("FAIL release_wait1 got=%0d exp=%0d", n, HOST_WAIT); end
        tick;
        h.host_addr = 8'h71;
        @(negedge clk);
        checks++; if ({h.host_ack, cpu_stall} !== 2'b11) begin failures++; $display("FAIL release_ack2 got=%b%b exp=11", h.host_ack, cpu_stall); end
        tick;
        h.host_req = 1'b0;
        @(negedge clk);
        checks++; if ({h.host_ack, cpu_stall} !== 2'b01) begin failures++; $display("FAIL release_drop got=%b%b exp=01", h.host_ack, cpu_stall); end
        tick;
        h.host_req = 1'b1;
        h.host_addr = 8'h80;
        @(negedge clk);
        checks++; if ({h.host_ack, cpu_stall, ram_rd_} !== 3'b000) begin failures++; $display("FAIL release_cpu_owns got=%b%b%b exp=000", h.host_ack, cpu_stall, ram_rd_); end
        tick;
        wait_ack(n);
        checks++; if (n !== HOST_WAIT - 1) begin failures++; $display("FAIL release_wait2 got=%0d exp=%0d", n + 1, HOST_WAIT); end
        count_acks(8'h80, k, st);
        checks++; if (k !== MAX_BURST) begin failures++; $display("FAIL release_burst2 got=%0d exp=%0d", k, MAX_BURST); end
        tick;
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
    endtask

    task automatic test_async_reset;
        host_op(1'b1, 1'b0, 8'h05, 8'h00);
        tick;
        tick;
        host_op(1'b1, 1'b1, 8'h61, 8'hEE);
        cpu_op(1'b0, 1'b1, 8'h02, 8'h00);
        @(negedge clk);
        checks++; if ({h.host_ack, ram_wr_, h.host_rvalid, h.host_rdat} !== {3'b101, init_val(8'h05)}) begin failures++; $display("FAIL areset_pre got=%b%b%b/%h exp=101/%h", h.host_ack, ram_wr_, h.host_rvalid, h.host_rdat, init_val(8'h05)); end
        #2;
        rst_ = 1'b0;
        #1;
        checks++; if ({ram_wr_, h.host_ack, cpu_stall, h.host_rvalid} !== 4'b1000) begin failures++; $display("FAIL areset_same_cycle got=%b%b%b%b exp=1000", ram_wr_, h.host_ack, cpu_stall, h.host_rvalid); end
        tick;
        tick;
        rst_ = 1'b1;
        @(negedge clk);
        checks++; if ({h.host_ack, cpu_stall, ram_rd_} !== 3'b000) begin failures++; $display("FAIL areset_cpu_owns got=%b%b%b exp=000", h.host_ack, cpu_stall, ram_rd_); end
        checks++; if (mem[8'h61] !== init_val(8'h61)) begin failures++; $display("FAIL areset_no_write got=%h exp=%h", mem[8'h61], init_val(8'h61)); end
        tick;
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
    endtask

    task automatic test_random;
        bit         own, ev, cacc, e_ack, e_stall, e_rd, e_wr;
        int         waited, acks, r, bad;
        logic [7:0] erd, e_addr;
        rst_ = 1'b0;
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
        tick;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        own = 0; ev = 0; waited = 0; acks = 0; erd = 8'h00;
        rst_ = 1'b1;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 15);
            if (r <= (c < 300 ? 3 : 0)) cpu_op(1'b1, 1'b1, 8'(c), 8'h00);
            else if (r < 9) cpu_op(1'b0, 1'b1, 8'($urandom_range(0, 15)), 8'h00);
            else if (r < 15) cpu_op(1'b1, 1'b0, 8'($urandom_range(0, 15)), 8'($urandom));
            else cpu_op(1'b0, 1'b0, 8'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 7) == 0) h.host_req = ~h.host_req;
            h.host_we = 1'($urandom_range(0, 1));
            h.host_addr = 8'($urandom_range(0, 15));
            h.host_wdat = 8'($urandom);
            cacc = !cpu_rd_ || !cpu_wr_;
            @(negedge clk);
            e_ack = own && h.host_req;
            e_stall = own && cacc;
            e_wr = e_ack ? !h.host_we : !(!own && !cpu_wr_);
            e_rd = e_ack ? h.host_we : !(!own && !cpu_rd_ && cpu_wr_);
            e_addr = e_ack ? h.host_addr : cpu_addr;
            checks++;
            if ({h.host_ack, cpu_stall, ram_rd_, ram_wr_, h.host_rvalid} !== {e_ack, e_stall, e_rd, e_wr, ev}) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d ack/stall/rd/wr/rvalid got=%b%b%b%b%b exp=%b%b%b%b%b", c, h.host_ack, cpu_stall, ram_rd_, ram_wr_, h.host_rvalid, e_ack, e_stall, e_rd, e_wr, ev);
            end
            if (!e_rd || !e_wr) begin
                checks++; if (ram_addr !== e_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, ram_addr, e_addr); end
            end
            if (ev) begin
                checks++; if (h.host_rdat !== erd) begin failures++; $display("FAIL rand_host_rdat cyc=%0d got=%h exp=%h", c, h.host_rdat, erd); end
            end
            if (!own && !cpu_rd_ && cpu_wr_) begin
                checks++; if (cpu_rdat !== ref_mem[cpu_addr]) begin failures++; $display("FAIL rand_cpu_rdat cyc=%0d got=%h exp=%h", c, cpu_rdat, ref_mem[cpu_addr]); end
            end
            @(posedge clk);
            ev = e_ack && !h.host_we;
            if (ev) erd = ref_mem[h.host_addr];
            if (own) begin
                if (e_ack && h.host_we) ref_mem[h.host_addr] = h.host_wdat;
                if (e_ack && acks < MAX_BURST) acks++;
                if (!h.host_req || (cacc && acks >= MAX_BURST)) begin
                    own = 0; acks = 0; waited = 0;
                end
            end else begin
                if (!cpu_wr_) ref_mem[cpu_addr] = cpu_wdat;
                if (!h.host_req) waited = 0;
                else if (!cacc) begin own = 1; waited = 0; end
                else begin
                    waited++;
                    if (waited == HOST_WAIT) begin own = 1; waited = 0; end
                end
            end
            #1;
        end
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h00, 8'h00);
        tick;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_mem_image got=%0d differing bytes exp=0", bad); end
    endtask

    initial begin
        host_op(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        load = 1'b0;
        test_reset;
        test_idle_steal;
        test_forced;
        test_burst_hold;
        test_release;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
